// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage and 32-entry architectural register file.
//
// Captures decoded rs1/rs2/rd indices from decode under the four-state
// ready-to-send/ready-to-receive handshake. It presents forwarded operands to
// execute from the captured indices.
//
// Optional feature macro: OPERAND_FETCH_BYPASS_EN.
//   Defined   - the bypass port and the same-cycle write path forward into
//               the operands.
//   Undefined - operands come from the register file only. A write becomes
//               visible one cycle after its strobe.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   startSig                   pipeline start pulse
//   beforePipReadyToSend       decode holds a valid item
//   nextPipReadyToRcv          execute can accept
//   curPipReadyToRcv           this stage accepts from decode this cycle
//   curPipReadyToSend          this stage holds a valid item for execute
//   dec_rs1/rs2/rd_idx         decoded register indices
//   dec_rd_valid               instruction writes rd
//   rf_wr_idx/val/en           write-back write port
//   bp_idx/val                 write-back bypass port (bp_idx 0 = none)
//   op_rs1_val, op_rs2_val     forwarded operands
//   op_rd_idx, op_rd_valid     captured rd fields
module operand_fetch #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_IDX = 5,
  parameter int unsigned AMT_REG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startSig,
  input  logic               beforePipReadyToSend,
  input  logic               nextPipReadyToRcv,
  output logic               curPipReadyToRcv,
  output logic               curPipReadyToSend,
  input  logic [REG_IDX-1:0] dec_rs1_idx,
  input  logic [REG_IDX-1:0] dec_rs2_idx,
  input  logic [REG_IDX-1:0] dec_rd_idx,
  input  logic               dec_rd_valid,
  input  logic [REG_IDX-1:0] rf_wr_idx,
  input  logic [XLEN-1:0]    rf_wr_val,
  input  logic               rf_wr_en,
  input  logic [REG_IDX-1:0] bp_idx,
  input  logic [XLEN-1:0]    bp_val,
  output logic [XLEN-1:0]    op_rs1_val,
  output logic [XLEN-1:0]    op_rs2_val,
  output logic [REG_IDX-1:0] op_rd_idx,
  output logic               op_rd_valid
);

  localparam logic [2:0] stIdle     = 3'b000;
  localparam logic [2:0] stWaitBef  = 3'b001;
  localparam logic [2:0] stSending  = 3'b010;
  localparam logic [2:0] stWaitSend = 3'b100;

  logic [2:0]         stateQ, stateD;
  logic [REG_IDX-1:0] rs1IdxQ, rs2IdxQ, rdIdxQ;
  logic               rdValidQ;
  logic               accept;
  logic [XLEN-1:0]    rf [AMT_REG];

  // Handshake
  assign curPipReadyToSend = (stateQ == stSending) || (stateQ == stWaitSend);
  assign curPipReadyToRcv  = (stateQ == stWaitBef) || (curPipReadyToSend && nextPipReadyToRcv);
  assign accept            = beforePipReadyToSend && (startSig || curPipReadyToRcv);

  always_comb begin
    stateD = stateQ;
    if (startSig) begin
      stateD = beforePipReadyToSend ? stSending : stWaitBef;
    end else begin
      case (stateQ)
        stWaitBef: stateD = beforePipReadyToSend ? stSending : stWaitBef;
        stSending, stWaitSend: begin
          if (nextPipReadyToRcv) stateD = beforePipReadyToSend ? stSending : stWaitBef;
          else                   stateD = stWaitSend;
        end
        default: stateD = stIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= stIdle;
      rs1IdxQ  <= '0;
      rs2IdxQ  <= '0;
      rdIdxQ   <= '0;
      rdValidQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        rs1IdxQ  <= dec_rs1_idx;
        rs2IdxQ  <= dec_rs2_idx;
        rdIdxQ   <= dec_rd_idx;
        rdValidQ <= dec_rd_valid;
      end
    end
  end

  // Register file; entry 0 is never written and reads as 0 through the operand mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(AMT_REG); i++) rf[i] <= '0;
    end else if (rf_wr_en && (rf_wr_idx != '0)) begin
      rf[rf_wr_idx] <= rf_wr_val;
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  function automatic logic [XLEN-1:0] readOperand(input logic [REG_IDX-1:0] idx);
    if (idx == '0)                          return '0;
    else if (bp_idx != '0 && bp_idx == idx) return bp_val;
    else if (rf_wr_en && rf_wr_idx == idx)  return rf_wr_val;
    else                                    return rf[idx];
  endfunction
`else
  function automatic logic [XLEN-1:0] readOperand(input logic [REG_IDX-1:0] idx);
    if (idx == '0) return '0;
    else           return rf[idx];
  endfunction

  // Bypass port is intentionally ignored in this build.
  logic unusedBypass;
  assign unusedBypass = ^{bp_idx, bp_val};
`endif

  // Re-evaluated every cycle so late writes are seen while waiting to send.
  assign op_rs1_val  = readOperand(rs1IdxQ);
  assign op_rs2_val  = readOperand(rs2IdxQ);
  assign op_rd_idx   = rdIdxQ;
  assign op_rd_valid = rdValidQ;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage and architectural register file for the RV32I multicycle pipeline. It receives decoded register indices from the decode stage and owns the 32-entry integer register file. The write-back stage writes that file through the write port and forwards in-flight results through the bypass port. The stage presents forwarded rs1/rs2 operands to execute under the same four-state ready-to-send/ready-to-receive pipeline handshake used across the pipeline.

## Interface
- XLEN, 32, data width
- REG_IDX, 5, register index width
- AMT_REG, 32, number of architectural registers
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- startSig  in  1  pipeline start pulse
- beforePipReadyToSend  in  1  decode stage holds a valid item
- nextPipReadyToRcv  in  1  execute stage can accept
- curPipReadyToRcv  out  1  this stage accepts from decode this cycle
- curPipReadyToSend  out  1  this stage holds a valid item for execute
- dec_rs1_idx, dec_rs2_idx, dec_rd_idx  in  REG_IDX each  decoded indices
- dec_rd_valid  in  1  instruction writes rd
- rf_wr_idx  in  REG_IDX  write-back register index
- rf_wr_val  in  XLEN  write-back data
- rf_wr_en  in  1  write-back write strobe
- bp_idx  in  REG_IDX  bypass index; 0 means no bypass
- bp_val  in  XLEN  bypass data
- op_rs1_val, op_rs2_val  out  XLEN  forwarded operands
- op_rd_idx  out  REG_IDX  captured rd
- op_rd_valid  out  1  captured rd-valid

## Operation
- FSM encoding: idle=3'b000, waitBef=3'b001, sending=3'b010, waitSend=3'b100.
- curPipReadyToSend = sending | waitSend.
- curPipReadyToRcv = waitBef | (curPipReadyToSend & nextPipReadyToRcv).
- accept = beforePipReadyToSend & (startSig | curPipReadyToRcv).
- On accept: capture dec_rs1_idx, dec_rs2_idx, dec_rd_idx, dec_rd_valid.
- Transitions, in priority order:
  - rst → idle.
  - startSig → sending if beforePipReadyToSend, else waitBef.
  - waitBef → sending if beforePipReadyToSend, else waitBef.
  - sending/waitSend with nextPipReadyToRcv → sending if beforePipReadyToSend, else waitBef.
  - sending/waitSend without nextPipReadyToRcv → waitSend.
  - idle stays idle.
- A transfer to execute occurs in every cycle where curPipReadyToSend & nextPipReadyToRcv.
- Register file write: rf[rf_wr_idx] <= rf_wr_val on posedge when rf_wr_en & rf_wr_idx!=0. Entry 0 always reads 0.
- Operand n, combinational from the captured index, in priority order:
  1. index==0 → 0
  2. bp_idx!=0 & bp_idx==index → bp_val
  3. rf_wr_en & rf_wr_idx==index → rf_wr_val
  4. otherwise → rf[index]
- Operands re-evaluate every cycle, so a write landing while in waitSend is reflected before the transfer.
- op_rd_idx and op_rd_valid are registered copies of the captured fields.

## Timing
- Reset values:
  - FSM idle.
  - All rf entries 0.
  - Captured indices 0, captured rd-valid 0.
  - curPipReadyToSend=0, curPipReadyToRcv=0, op_rs1_val=op_rs2_val=0, op_rd_idx=0, op_rd_valid=0.
- Latency: accept at edge N → curPipReadyToSend=1 in cycle N+1, operands valid in that cycle.
- Throughput: one item per cycle when both neighbours are continuously ready.
- rst with startSig or rf_wr_en in the same cycle: rst wins, no capture, no write.
- rst mid-transfer: the held item is dropped.
- Write and read of the same index in the same cycle: forwarded value is driven that cycle; the array is updated at the edge.
- bp_idx==rf_wr_idx with different data: bp_val wins.
- Outside sending/waitSend, operand outputs are don't-care for execute but still follow the rules above.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined: priority levels 2 and 3 active.
- OPERAND_FETCH_BYPASS_EN undefined:
  - operand = 0 for index 0, else rf[index].
  - bp_idx, bp_val and the same-cycle write path are ignored.
  - A write becomes visible one cycle after its strobe.

## Test plan
- Reset, then rf_wr_en with idx=5, val=0xDEADBEEF → rf[5] written; capture rs1=5 → op_rs1_val=0xDEADBEEF.
- Write idx=0, val=0x1234 → reading x0 returns 0; bypass with bp_idx=0 is ignored.
- startSig with beforePipReadyToSend=1 → curPipReadyToSend=1 next cycle. Hold nextPipReadyToRcv=0 for 3 cycles → state waitSend, indices held; release → transfer, then sending or waitBef per beforePipReadyToSend.
- Captured rs2=7, bp_idx=7/bp_val=0xAA and rf_wr_idx=7/rf_wr_val=0xBB in the same cycle → op_rs2_val=0xAA (bypass on); =old rf[7] (bypass off).
- Back-to-back stream of 4 items with both neighbours always ready → 4 transfers in 4 consecutive cycles with correct rd_idx order.
- Assert rst while in waitSend with rf_wr_en=1 → next cycle idle, all outputs 0, write discarded.
